// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fp_pkg
// Description : Shared floating-point types and helpers. Holds the format
//               selector with its width functions, the IEEE rounding modes,
//               the unrounded result bundle produced by the FMA/add datapath,
//               the fflags structure with bit-index constants, and a constant
//               function that builds the largest finite encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP64 = 2'd1,
        FP16 = 2'd2,
        BF16 = 2'd3
    } fp_format_e;

    // The bundle always carries the widest supported encoding. Narrower
    // formats occupy its low bits.
    localparam int MAX_FP_WIDTH = 64;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } roundmode_e;

    typedef struct packed {
        logic [MAX_FP_WIDTH-1:0] u_result;  // {sign, exp, mant} in low bits
        logic [1:0]              rs;        // {round, sticky}
        logic                    round_en;
        logic                    invalid;
        logic [1:0]              exp_cout;  // exponent carry-out from upstream
    } uround_res_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    function automatic int fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            BF16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int exp_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int man_bits(fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

    // Largest finite magnitude: exponent all-ones except its LSB, mantissa
    // all-ones, sign placed just above the exponent.
    function automatic logic [MAX_FP_WIDTH-1:0] max_finite(fp_format_e fmt, logic sign);
        logic [MAX_FP_WIDTH-1:0] v;
        int ew;
        int mw;
        ew = exp_bits(fmt);
        mw = man_bits(fmt);
        v  = '0;
        for (int i = 0; i < MAX_FP_WIDTH; i++) begin
            if (i < ew + mw) begin
                v[i] = 1'b1;
            end
        end
        v[mw]      = 1'b0;
        v[mw + ew] = sign;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_rnd_core.sv
`default_nettype none
// ============================================================================
// Module      : fp_rnd_core
// Description : Purely combinational rounding logic. Two independent halves:
//               the first derives the increment decision and inexact bit from
//               the incoming bundle; the second applies the increment,
//               resolves overflow by rounding mode and packs fflags.
// Ports       : sign_i, lsb_i, rs_i, rnd_s1_i  -> inc_o, inexact_o
//               op_i, round_en_i, invalid_i, exp_cout_i, rnd_s2_i, inc_i,
//               inexact_i, round_only_i, mul_ovf_i, mul_uf_i, mul_uround_i
//                                              -> result_o, flags_o
// Revision    : 1.0 - initial release
// ============================================================================
module fp_rnd_core
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT  = FP32,
    localparam int        FP_WIDTH   = fp_width(FP_FORMAT),
    localparam int        EXP_WIDTH  = exp_bits(FP_FORMAT),
    localparam int        MANT_WIDTH = man_bits(FP_FORMAT)
) (
    // increment decision
    input  logic                sign_i,
    input  logic                lsb_i,
    input  logic [1:0]          rs_i,
    input  roundmode_e          rnd_s1_i,
    output logic                inc_o,
    output logic                inexact_o,
    // result packing
    input  logic [FP_WIDTH-1:0] op_i,
    input  logic                round_en_i,
    input  logic                invalid_i,
    input  logic [1:0]          exp_cout_i,
    input  roundmode_e          rnd_s2_i,
    input  logic                inc_i,
    input  logic                inexact_i,
    input  logic                round_only_i,
    input  logic                mul_ovf_i,
    input  logic                mul_uf_i,
    input  logic                mul_uround_i,
    output logic [FP_WIDTH-1:0] result_o,
    output fflags_t             flags_o
);

    localparam int MAG_WIDTH = EXP_WIDTH + MANT_WIDTH;

    logic w_r;
    logic w_s;
    assign w_r = rs_i[1];
    assign w_s = rs_i[0];

    always_comb begin
        inc_o = 1'b0;
        case (rnd_s1_i)
            RNE:     inc_o = w_r & (w_s | lsb_i);
            RTZ:     inc_o = 1'b0;
            RDN:     inc_o = sign_i & (w_r | w_s);
            RUP:     inc_o = ~sign_i & (w_r | w_s);
            RMM:     inc_o = w_r;
            default: inc_o = w_r & (w_s | lsb_i);
        endcase
    end

    assign inexact_o = w_r | w_s;

    logic                    w_sign;
    logic [EXP_WIDTH-1:0]    w_exp_pre;
    logic [EXP_WIDTH-1:0]    w_exp_post;
    logic [MAG_WIDTH-1:0]    w_mag;
    logic                    w_of;
    logic                    w_nx;
    logic                    w_tiny;
    logic [FP_WIDTH-1:0]     w_inf;
    logic [FP_WIDTH-1:0]     w_max;
    logic [MAX_FP_WIDTH-1:0] w_max_full;

    assign w_sign    = op_i[FP_WIDTH-1];
    assign w_exp_pre = op_i[FP_WIDTH-2:MANT_WIDTH];

    // One add across exponent and mantissa: a mantissa carry naturally bumps
    // the exponent, which also promotes a rounded-up subnormal to normal.
    assign w_mag      = op_i[MAG_WIDTH-1:0] + {{(MAG_WIDTH-1){1'b0}}, inc_i};
    assign w_exp_post = w_mag[MAG_WIDTH-1:MANT_WIDTH];

    assign w_of   = (exp_cout_i != 2'b00) | mul_ovf_i | (&w_exp_post);
    assign w_nx   = inexact_i | w_of;
    // Tiny before rounding, unless the result reached the normal range and
    // upstream says it is not tiny after rounding.
    assign w_tiny = ((w_exp_pre == '0) | (round_only_i & mul_uf_i))
                  & ~((w_exp_post != '0) & mul_uround_i);

    assign w_inf      = {w_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    assign w_max_full = max_finite(FP_FORMAT, w_sign);
    assign w_max      = w_max_full[FP_WIDTH-1:0];

    generate
        if (FP_WIDTH < MAX_FP_WIDTH) begin : g_unused_max
            logic unused_max_bits;
            assign unused_max_bits = ^w_max_full[MAX_FP_WIDTH-1:FP_WIDTH];
        end
    endgenerate

    always_comb begin
        result_o   = op_i;
        flags_o    = '0;
        flags_o.nv = invalid_i;
        if (round_en_i) begin
            flags_o.of = w_of;
            flags_o.nx = w_nx;
            flags_o.uf = w_tiny & w_nx;
            if (w_of) begin
                case (rnd_s2_i)
                    RTZ:     result_o = w_max;
                    RDN:     result_o = w_sign ? w_inf : w_max;
                    RUP:     result_o = w_sign ? w_max : w_inf;
                    default: result_o = w_inf;
                endcase
            end else begin
                result_o = {w_sign, w_mag};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_rnd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_rnd_pipe
// Description : Two-stage rounding and exception-packing pipeline between the
//               FMA/add datapath and FPU writeback. Stage 1 registers the
//               bundle with its increment decision; stage 2 registers the
//               final encoding and fflags. Valid/ready on both sides, one
//               result per cycle, stalled stages hold their contents.
// Ports       : clk_i, rst_ni (async, active-low)
//               valid_i, ready_o, urnd_i, rnd_i, round_only_i, mul_ovf_i,
//               mul_uf_i, mul_uround_i                 - upstream side
//               valid_o, ready_i, result_o, flags_o    - downstream side
//               clr_flags_i, flags_acc_o               - only with
//               FP_RND_FLAGS_ACC_EN defined (sticky flag accumulator)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_rnd_pipe
    import fp_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32,
    localparam int        FP_WIDTH  = fp_width(FP_FORMAT)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    output logic                ready_o,
    input  uround_res_t         urnd_i,
    input  roundmode_e          rnd_i,
    input  logic                round_only_i,
    input  logic                mul_ovf_i,
    input  logic                mul_uf_i,
    input  logic                mul_uround_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [FP_WIDTH-1:0] result_o,
    output fflags_t             flags_o
`ifdef FP_RND_FLAGS_ACC_EN
    ,
    input  logic                clr_flags_i,
    output fflags_t             flags_acc_o
`endif
);

    typedef struct packed {
        logic [FP_WIDTH-1:0] op;
        logic                round_en;
        logic                invalid;
        logic [1:0]          exp_cout;
        roundmode_e          rnd;
        logic                inc;
        logic                inexact;
        logic                round_only;
        logic                mul_ovf;
        logic                mul_uf;
        logic                mul_uround;
    } s1_t;

    logic                init_q;
    logic                s1_valid_q, s1_valid_d;
    s1_t                 s1_q, s1_d;
    logic                s2_valid_q, s2_valid_d;
    logic [FP_WIDTH-1:0] result_q, result_d;
    fflags_t             flags_q, flags_d;

    logic                w_adv1;
    logic                w_adv2;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_inc;
    logic                w_inexact;
    logic [FP_WIDTH-1:0] w_result;
    fflags_t             w_flags;

    assign w_adv2     = ~s2_valid_q | ready_i;
    assign w_adv1     = ~s1_valid_q | w_adv2;
    // init_q keeps ready low until the first clock after reset release.
    assign ready_o    = init_q & w_adv1;
    assign w_in_xfer  = valid_i & ready_o;
    assign w_out_xfer = s2_valid_q & ready_i;

    fp_rnd_core #(
        .FP_FORMAT (FP_FORMAT)
    ) u_core (
        .sign_i       (urnd_i.u_result[FP_WIDTH-1]),
        .lsb_i        (urnd_i.u_result[0]),
        .rs_i         (urnd_i.rs),
        .rnd_s1_i     (rnd_i),
        .inc_o        (w_inc),
        .inexact_o    (w_inexact),
        .op_i         (s1_q.op),
        .round_en_i   (s1_q.round_en),
        .invalid_i    (s1_q.invalid),
        .exp_cout_i   (s1_q.exp_cout),
        .rnd_s2_i     (s1_q.rnd),
        .inc_i        (s1_q.inc),
        .inexact_i    (s1_q.inexact),
        .round_only_i (s1_q.round_only),
        .mul_ovf_i    (s1_q.mul_ovf),
        .mul_uf_i     (s1_q.mul_uf),
        .mul_uround_i (s1_q.mul_uround),
        .result_o     (w_result),
        .flags_o      (w_flags)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (w_adv1) begin
            s1_valid_d = w_in_xfer;
        end
        // Payload only loads on an accepted bundle; otherwise it holds.
        if (w_in_xfer) begin
            s1_d.op         = urnd_i.u_result[FP_WIDTH-1:0];
            s1_d.round_en   = urnd_i.round_en;
            s1_d.invalid    = urnd_i.invalid;
            s1_d.exp_cout   = urnd_i.exp_cout;
            s1_d.rnd        = rnd_i;
            s1_d.inc        = w_inc;
            s1_d.inexact    = w_inexact;
            s1_d.round_only = round_only_i;
            s1_d.mul_ovf    = mul_ovf_i;
            s1_d.mul_uf     = mul_uf_i;
            s1_d.mul_uround = mul_uround_i;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
        if (w_adv2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = w_result;
                flags_d  = w_flags;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q     <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            init_q     <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    assign valid_o  = s2_valid_q;
    assign result_o = result_q;
    assign flags_o  = flags_q;

`ifdef FP_RND_FLAGS_ACC_EN
    fflags_t flags_acc_q, flags_acc_d;

    // Clear wins over the held value, but a transfer in the same cycle still
    // contributes its flags to the freshly cleared accumulator.
    always_comb begin
        flags_acc_d = clr_flags_i ? fflags_t'('0) : flags_acc_q;
        if (w_out_xfer) begin
            flags_acc_d = fflags_t'(flags_acc_d | flags_q);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_acc_q <= '0;
        end else begin
            flags_acc_q <= flags_acc_d;
        end
    end

    assign flags_acc_o = flags_acc_q;
`else
    logic unused_out_xfer;
    assign unused_out_xfer = w_out_xfer;
`endif

    generate
        if (FP_WIDTH < MAX_FP_WIDTH) begin : g_unused_in
            logic unused_in_bits;
            assign unused_in_bits = ^urnd_i.u_result[MAX_FP_WIDTH-1:FP_WIDTH];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fp_rnd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_rnd_pipe
// Description : Self-checking bench for fp_rnd_pipe (FP32). A behavioural
//               model computes each accepted bundle's expected encoding and
//               fflags with plain arithmetic; a scoreboard queue holds them in
//               order and one negedge monitor compares every output transfer
//               and checks stall stability.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_rnd_pipe;
    import fp_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    uround_res_t urnd;
    roundmode_e  rnd;
    logic        round_only;
    logic        mul_ovf;
    logic        mul_uf;
    logic        mul_uround;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  flags_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [36:0] sb[$];

    fp_rnd_pipe #(
        .FP_FORMAT (FP32)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .urnd_i       (urnd),
        .rnd_i        (rnd),
        .round_only_i (round_only),
        .mul_ovf_i    (mul_ovf),
        .mul_uf_i     (mul_uf),
        .mul_uround_i (mul_uround),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .flags_o      (flags_o)
`ifdef FP_RND_FLAGS_ACC_EN
        ,
        .clr_flags_i  (1'b0),
        .flags_acc_o  ()
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [63:0] got, logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    // Reference: FP32 rounding straight from the IEEE rules. Returns
    // {result[31:0], flags{nv,dz,of,uf,nx}}.
    function automatic logic [36:0] model(uround_res_t b, roundmode_e m,
                                          logic ro, logic ovf, logic uf, logic ur);
        logic [31:0] u;
        logic        sign, r, s, inc, of, nx, tiny, to_inf;
        logic [31:0] sum;
        logic [7:0]  e_pre, e_post;
        logic [31:0] res;
        u     = b.u_result[31:0];
        sign  = u[31];
        r     = b.rs[1];
        s     = b.rs[0];
        case (m)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (r | s);
            RUP:     inc = !sign & (r | s);
            RMM:     inc = r;
            default: inc = r & (s | u[0]);
        endcase
        sum    = {1'b0, u[30:0]} + {31'd0, inc};
        e_pre  = u[30:23];
        e_post = sum[30:23];
        of     = (b.exp_cout != 2'b00) || ovf || (e_post == 8'hFF);
        nx     = r || s || of;
        tiny   = ((e_pre == 8'd0) || (ro && uf)) && !((e_post != 8'd0) && ur);
        if (!b.round_en) begin
            return {u, b.invalid, 4'b0000};
        end
        if (of) begin
            to_inf = (m == RDN) ? sign : (m == RUP) ? !sign : (m != RTZ);
            res    = {sign, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
        end else begin
            res = {sign, sum[30:0]};
        end
        return {res, b.invalid, 1'b0, of, tiny && nx, nx};
    endfunction

    // Scoreboard and stall-stability monitor, sampled mid-cycle.
    logic [36:0] mon_exp;
    logic [36:0] mon_prev;
    logic        mon_hold = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            mon_hold = 1'b0;
        end else begin
            if (mon_hold) begin
                check("hold_valid", {63'd0, valid_o}, 64'd1);
                check("hold_data", {27'd0, result_o, flags_o}, {27'd0, mon_prev});
            end
            mon_hold = valid_o && !ready_i;
            mon_prev = {result_o, flags_o};
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", {63'd0, valid_o}, 64'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    check("result", {32'd0, result_o}, {32'd0, mon_exp[36:5]});
                    check("flags", {59'd0, flags_o}, {59'd0, mon_exp[4:0]});
                end
            end
            if (valid_i && ready_o) begin
                sb.push_back(model(urnd, rnd, round_only, mul_ovf, mul_uf, mul_uround));
            end
        end
    end

    task automatic set_in(logic [31:0] u, logic [1:0] rs, logic ren, logic inv,
                          logic [1:0] ec, roundmode_e m, logic ro, logic ovf,
                          logic uf, logic ur);
        urnd.u_result = {32'd0, u};
        urnd.rs       = rs;
        urnd.round_en = ren;
        urnd.invalid  = inv;
        urnd.exp_cout = ec;
        rnd           = m;
        round_only    = ro;
        mul_ovf       = ovf;
        mul_uf        = uf;
        mul_uround    = ur;
    endtask

    task automatic set_rand();
        set_in($urandom, 2'($urandom_range(0, 3)), ($urandom % 8) != 0,
               ($urandom % 8) == 0,
               (($urandom % 8) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
               roundmode_e'(3'($urandom_range(0, 4))),
               ($urandom % 4) == 0, ($urandom % 16) == 0,
               ($urandom % 4) == 0, ($urandom % 2) == 0);
    endtask

    // Present the current inputs until accepted (bounded), then drop valid.
    task automatic send();
        logic ok;
        ok      = 1'b0;
        valid_i = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = ready_o;
        end
        if (!ok) check("send_timeout", {63'd0, ready_o}, 64'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic directed(string name, logic [31:0] u, logic [1:0] rs,
                            roundmode_e m, logic ovf, logic ur,
                            logic [31:0] exp_res, logic [4:0] exp_fl);
        set_in(u, rs, 1'b1, 1'b0, 2'b00, m, 1'b0, ovf, 1'b0, ur);
        check(name, {27'd0, model(urnd, rnd, round_only, mul_ovf, mul_uf, mul_uround)},
              {27'd0, exp_res, exp_fl});
        send();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || valid_o) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", {32'd0, sb.size()}, 64'd0);
    endtask

    task automatic bp_release();
        logic saw_low;
        saw_low = 1'b0;
        for (int k = 0; k < 20 && !saw_low; k++) begin
            @(negedge clk);
            saw_low = !ready_o;
        end
        check("bp_ready_low", {63'd0, saw_low}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
    endtask

    task automatic bp_send4();
        for (int i = 0; i < 4; i++) begin
            set_rand();
            send();
        end
    endtask

    int stale;

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        set_in(32'd0, 2'b00, 1'b0, 1'b0, 2'b00, RNE, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, valid_o}, 64'd0);
        check("rst_result", {32'd0, result_o}, 64'd0);
        check("rst_flags", {59'd0, flags_o}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", {63'd0, ready_o}, 64'd1);
        ready_i = 1'b1;

        // Latency: accepted on one edge, visible after the next.
        directed("tie_even", 32'h3F80_0000, 2'b10, RNE, 1'b0, 1'b0, 32'h3F80_0000, 5'b00001);
        check("latency_1", {63'd0, valid_o}, 64'd0);
        @(posedge clk);
        #1;
        check("latency_2", {63'd0, valid_o}, 64'd1);

        directed("tie_odd_rne", 32'h3F80_0001, 2'b10, RNE, 1'b0, 1'b0, 32'h3F80_0002, 5'b00001);
        directed("tie_odd_rtz", 32'h3F80_0001, 2'b10, RTZ, 1'b0, 1'b0, 32'h3F80_0001, 5'b00001);
        directed("mant_carry", 32'h3FFF_FFFF, 2'b01, RUP, 1'b0, 1'b0, 32'h4000_0000, 5'b00001);
        directed("ovf_rne", 32'h7F7F_FFFF, 2'b11, RNE, 1'b0, 1'b0, 32'h7F80_0000, 5'b00101);
        // RTZ and RUP-on-negative never increment, so overflow comes from upstream.
        directed("ovf_rtz", 32'h7F7F_FFFF, 2'b11, RTZ, 1'b1, 1'b0, 32'h7F7F_FFFF, 5'b00101);
        directed("ovf_rup_neg", 32'hFF7F_FFFF, 2'b11, RUP, 1'b1, 1'b0, 32'hFF7F_FFFF, 5'b00101);
        directed("tiny_uf", 32'h007F_FFFF, 2'b11, RNE, 1'b0, 1'b0, 32'h0080_0000, 5'b00011);
        directed("tiny_uround", 32'h007F_FFFF, 2'b11, RNE, 1'b0, 1'b1, 32'h0080_0000, 5'b00001);
        drain();

        // Backpressure: four bundles against a stalled sink.
        ready_i = 1'b0;
        fork
            bp_send4();
            bp_release();
        join
        drain();

        // Reset with entries in flight.
        ready_i = 1'b0;
        set_rand();
        send();
        set_rand();
        send();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {63'd0, valid_o}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        stale   = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_o) stale++;
        end
        check("no_stale_output", {32'd0, stale}, 64'd0);

        // Random traffic on both sides.
        @(posedge clk);
        #1;
        for (int c = 0; c < 500; c++) begin
            set_rand();
            valid_i = ($urandom % 10) < 7;
            ready_i = ($urandom % 4) != 0;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
